// File: rtl/cvxif_offload_unit_pkg.sv
// Shared types for the CV-X-IF offload unit: core-side riscv/cvxif channel subset plus local table/queue records.
// CVXIF_TIMEOUT_EN adds instr and watchdog counter fields to every in-flight table entry.
package cvxif_offload_unit_pkg;

  localparam int unsigned XLEN          = 32;
  localparam int unsigned TRANS_ID_BITS = 3;
  localparam int unsigned X_NUM_RS      = 2;
  localparam int unsigned X_ID_WIDTH    = TRANS_ID_BITS;
  localparam int unsigned TO_CNT_BITS   = 16;

  typedef enum logic [1:0] {
    PRIV_LVL_U = 2'b00,
    PRIV_LVL_S = 2'b01,
    PRIV_LVL_M = 2'b11
  } priv_lvl_t;

  localparam logic [XLEN-1:0] ILLEGAL_INSTR = XLEN'(2);

  typedef struct packed {
    logic [XLEN-1:0] cause;
    logic [XLEN-1:0] tval;
    logic            valid;
  } exception_t;

  typedef struct packed {
    logic [31:0]                   instr;
    priv_lvl_t                     mode;
    logic [X_ID_WIDTH-1:0]         id;
    logic [X_NUM_RS-1:0][XLEN-1:0] rs;
    logic [X_NUM_RS-1:0]           rs_valid;
  } x_issue_req_t;

  typedef struct packed {
    logic accept;
  } x_issue_resp_t;

  typedef struct packed {
    logic [X_ID_WIDTH-1:0] id;
    logic                  x_kill;
  } x_commit_t;

  typedef struct packed {
    logic [X_ID_WIDTH-1:0] id;
    logic [XLEN-1:0]       data;
    logic                  we;
    logic                  exc;
    logic [5:0]            exccode;
  } x_result_t;

  typedef struct packed {
    logic         x_issue_valid;
    x_issue_req_t x_issue_req;
    logic         x_commit_valid;
    x_commit_t    x_commit;
    logic         x_result_ready;
  } cvxif_req_t;

  typedef struct packed {
    logic          x_issue_ready;
    x_issue_resp_t x_issue_resp;
    logic          x_result_valid;
    x_result_t     x_result;
  } cvxif_resp_t;

  typedef struct packed {
    logic                     valid;
    logic [TRANS_ID_BITS-1:0] id;
`ifdef CVXIF_TIMEOUT_EN
    logic [31:0]              instr;
    logic [TO_CNT_BITS-1:0]   cnt;
`endif
  } cvxif_tbl_entry_t;

  typedef struct packed {
    logic [TRANS_ID_BITS-1:0] id;
    logic [31:0]              instr;
  } cvxif_illegal_t;

  // Circular-buffer pointer advance for queues whose depth need not be a power of two.
  function automatic int unsigned wrap_inc(input int unsigned ptr, input int unsigned depth);
    return (ptr + 1 == depth) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/cvxif_inflight_tbl.sv
// Table of offloads accepted by the coprocessor and still awaiting a result.
// CVXIF_TIMEOUT_EN adds a per-entry watchdog that retires entries whose result never arrives.
module cvxif_inflight_tbl
  import cvxif_offload_unit_pkg::*;
#(
  parameter int unsigned NrEntries = 4
`ifdef CVXIF_TIMEOUT_EN
  , parameter int unsigned TimeoutCycles = 256
`endif
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic                     alloc_i,
  input  logic [TRANS_ID_BITS-1:0] alloc_id_i,
`ifdef CVXIF_TIMEOUT_EN
  input  logic [31:0]              alloc_instr_i,
  input  logic                     to_ack_i,
  output logic                     to_valid_o,
  output logic [TRANS_ID_BITS-1:0] to_id_o,
  output logic [31:0]              to_instr_o,
`endif
  input  logic                     lookup_valid_i,
  input  logic [TRANS_ID_BITS-1:0] lookup_id_i,
  output logic                     hit_o,
  output logic                     full_o
);

  localparam int unsigned IdxW = (NrEntries > 1) ? $clog2(NrEntries) : 1;

  cvxif_tbl_entry_t     tbl_q [NrEntries];
  cvxif_tbl_entry_t     tbl_d [NrEntries];
  logic [NrEntries-1:0] match;
  logic [NrEntries-1:0] busy;
  logic [IdxW-1:0]      hit_idx;
  logic [IdxW-1:0]      free_idx;

  // Downward scans so the lowest matching / lowest free index wins.
  always_comb begin
    match    = '0;
    busy     = '0;
    hit_idx  = '0;
    free_idx = '0;
    for (int i = int'(NrEntries) - 1; i >= 0; i--) begin
      busy[i]  = tbl_q[i].valid;
      match[i] = tbl_q[i].valid && (tbl_q[i].id == lookup_id_i);
      if (match[i]) hit_idx = IdxW'(i);
      if (!tbl_q[i].valid) free_idx = IdxW'(i);
    end
    hit_o  = lookup_valid_i && (|match);
    full_o = &busy;
  end

`ifdef CVXIF_TIMEOUT_EN
  localparam logic [TO_CNT_BITS-1:0] CntLimit = TO_CNT_BITS'(TimeoutCycles - 1);

  logic [NrEntries-1:0] expired;
  logic [IdxW-1:0]      to_idx;

  always_comb begin
    expired = '0;
    to_idx  = '0;
    for (int i = int'(NrEntries) - 1; i >= 0; i--) begin
      expired[i] = tbl_q[i].valid && (tbl_q[i].cnt == CntLimit);
      if (expired[i]) to_idx = IdxW'(i);
    end
    to_valid_o = |expired;
    to_id_o    = tbl_q[to_idx].id;
    to_instr_o = tbl_q[to_idx].instr;
  end
`endif

  // Alloc only targets a free slot, so it never collides with the slot being freed.
  always_comb begin
    tbl_d = tbl_q;
`ifdef CVXIF_TIMEOUT_EN
    for (int i = 0; i < int'(NrEntries); i++) begin
      if (tbl_q[i].valid && (tbl_q[i].cnt != CntLimit)) tbl_d[i].cnt = tbl_q[i].cnt + 1'b1;
    end
    if (to_ack_i) tbl_d[to_idx].valid = 1'b0;
`endif
    if (hit_o) tbl_d[hit_idx].valid = 1'b0;
    if (alloc_i) begin
      tbl_d[free_idx].valid = 1'b1;
      tbl_d[free_idx].id    = alloc_id_i;
`ifdef CVXIF_TIMEOUT_EN
      tbl_d[free_idx].instr = alloc_instr_i;
      tbl_d[free_idx].cnt   = '0;
`endif
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      for (int i = 0; i < int'(NrEntries); i++) tbl_q[i] <= '0;
    end else begin
      tbl_q <= tbl_d;
    end
  end

  dup_id: assert property (@(posedge clk_i) disable iff (rst_i)
    lookup_valid_i |-> ($countones(match) <= 1));

endmodule

// File: rtl/cvxif_offload_unit.sv
// CV-X-IF offload unit: issues to the coprocessor, tracks accepted offloads, queues rejected ones as
// illegal-instruction exceptions and multiplexes one writeback per cycle. Option: CVXIF_TIMEOUT_EN.
module cvxif_offload_unit
  import cvxif_offload_unit_pkg::*;
#(
  parameter int unsigned NrOutstanding = 4,
  parameter int unsigned IllegalQDepth = 2,
  parameter int unsigned NrRs          = 2,
  parameter int unsigned TimeoutCycles = 256
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  priv_lvl_t                priv_lvl_i,
  input  logic                     x_valid_i,
  output logic                     x_ready_o,
  input  logic [31:0]              x_off_instr_i,
  input  logic [TRANS_ID_BITS-1:0] x_trans_id_i,
  input  logic [NrRs*XLEN-1:0]     x_rs_i,
  output logic                     x_valid_o,
  output logic [TRANS_ID_BITS-1:0] x_trans_id_o,
  output logic [XLEN-1:0]          x_result_o,
  output logic                     x_we_o,
  output exception_t               x_exception_o,
  output cvxif_req_t               cvxif_req_o,
  input  cvxif_resp_t              cvxif_resp_i
);

  localparam int unsigned PtrW = (IllegalQDepth > 1) ? $clog2(IllegalQDepth) : 1;
  localparam int unsigned CntW = $clog2(IllegalQDepth + 1);

  logic tbl_full;
  logic tbl_hit;
  logic illq_full;
  logic illq_empty;
  logic issue_valid;
  logic fire;
  logic alloc;
  logic push;
  logic pop;

  cvxif_illegal_t                 illq_q [IllegalQDepth];
  cvxif_illegal_t                 illq_head;
  logic [PtrW-1:0]                wr_ptr_q;
  logic [PtrW-1:0]                rd_ptr_q;
  logic [CntW-1:0]                illq_cnt_q;
  logic [2**TRANS_ID_BITS-1:0]    stale_ok_q;

`ifdef CVXIF_TIMEOUT_EN
  logic                     to_valid;
  logic                     to_ack;
  logic [TRANS_ID_BITS-1:0] to_id;
  logic [31:0]              to_instr;
`endif

  assign illq_full   = (illq_cnt_q == CntW'(IllegalQDepth));
  assign illq_empty  = (illq_cnt_q == '0);
  assign issue_valid = x_valid_i & ~tbl_full & ~illq_full & ~flush_i;
  assign x_ready_o   = cvxif_resp_i.x_issue_ready & ~tbl_full & ~illq_full & ~flush_i;
  assign fire        = x_valid_i & x_ready_o;
  assign alloc       = fire & cvxif_resp_i.x_issue_resp.accept;
  assign push        = fire & ~cvxif_resp_i.x_issue_resp.accept;
  assign pop         = ~illq_empty & ~tbl_hit;
  assign illq_head   = illq_q[rd_ptr_q];
`ifdef CVXIF_TIMEOUT_EN
  assign to_ack      = to_valid & ~tbl_hit & illq_empty;
`endif

  cvxif_inflight_tbl #(
    .NrEntries     (NrOutstanding)
`ifdef CVXIF_TIMEOUT_EN
    , .TimeoutCycles (TimeoutCycles)
`endif
  ) u_tbl (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .flush_i        (flush_i),
    .alloc_i        (alloc),
    .alloc_id_i     (x_trans_id_i),
`ifdef CVXIF_TIMEOUT_EN
    .alloc_instr_i  (x_off_instr_i),
    .to_ack_i       (to_ack),
    .to_valid_o     (to_valid),
    .to_id_o        (to_id),
    .to_instr_o     (to_instr),
`endif
    .lookup_valid_i (cvxif_resp_i.x_result_valid),
    .lookup_id_i    (cvxif_resp_i.x_result.id),
    .hit_o          (tbl_hit),
    .full_o         (tbl_full)
  );

  // Payload fields stay zero unless an issue is actually offered, keeping the idle bus quiet.
  always_comb begin
    cvxif_req_o                = '0;
    cvxif_req_o.x_result_ready = 1'b1;
    cvxif_req_o.x_issue_valid  = issue_valid;
    cvxif_req_o.x_commit_valid = issue_valid;
    if (issue_valid) begin
      cvxif_req_o.x_issue_req.instr    = x_off_instr_i;
      cvxif_req_o.x_issue_req.mode     = priv_lvl_i;
      cvxif_req_o.x_issue_req.id       = x_trans_id_i;
      cvxif_req_o.x_issue_req.rs_valid = '1;
      cvxif_req_o.x_commit.id          = x_trans_id_i;
      for (int i = 0; i < int'(NrRs); i++) begin
        cvxif_req_o.x_issue_req.rs[i] = x_rs_i[i*XLEN +: XLEN];
      end
    end
  end

  always_comb begin
    x_valid_o     = 1'b0;
    x_trans_id_o  = '0;
    x_result_o    = '0;
    x_we_o        = 1'b0;
    x_exception_o = '0;
    if (tbl_hit) begin
      x_valid_o           = 1'b1;
      x_trans_id_o        = cvxif_resp_i.x_result.id;
      x_result_o          = cvxif_resp_i.x_result.data;
      x_we_o              = cvxif_resp_i.x_result.we;
      x_exception_o.valid = cvxif_resp_i.x_result.exc;
      x_exception_o.cause = XLEN'(cvxif_resp_i.x_result.exccode);
    end else if (!illq_empty) begin
      x_valid_o           = 1'b1;
      x_trans_id_o        = illq_head.id;
      x_exception_o.valid = 1'b1;
      x_exception_o.cause = ILLEGAL_INSTR;
      x_exception_o.tval  = XLEN'(illq_head.instr);
    end
`ifdef CVXIF_TIMEOUT_EN
    else if (to_valid) begin
      x_valid_o           = 1'b1;
      x_trans_id_o        = to_id;
      x_exception_o.valid = 1'b1;
      x_exception_o.cause = ILLEGAL_INSTR;
      x_exception_o.tval  = XLEN'(to_instr);
    end
`endif
  end

  always_ff @(posedge clk_i) begin
    if (push) illq_q[wr_ptr_q] <= '{id: x_trans_id_i, instr: x_off_instr_i};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      illq_cnt_q <= '0;
    end else begin
      if (push) wr_ptr_q <= PtrW'(wrap_inc(32'(wr_ptr_q), IllegalQDepth));
      if (pop)  rd_ptr_q <= PtrW'(wrap_inc(32'(rd_ptr_q), IllegalQDepth));
      illq_cnt_q <= illq_cnt_q + CntW'(push) - CntW'(pop);
    end
  end

  // Ids whose late results may legitimately go unmatched: flushed or timed out since their issue.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stale_ok_q <= '0;
    end else if (flush_i) begin
      stale_ok_q <= '1;
    end else begin
`ifdef CVXIF_TIMEOUT_EN
      if (to_ack) stale_ok_q[to_id] <= 1'b1;
`endif
      if (alloc) stale_ok_q[x_trans_id_i] <= 1'b0;
    end
  end

  stale_result: assert property (@(posedge clk_i) disable iff (rst_i)
    (cvxif_resp_i.x_result_valid && !tbl_hit) |-> stale_ok_q[cvxif_resp_i.x_result.id]);

  cfg_ok: assert property (@(posedge clk_i)
    (NrOutstanding >= 1) && (IllegalQDepth >= 1) && (NrRs == X_NUM_RS) && (TimeoutCycles >= 2));

endmodule

// File: tb/tb_cvxif_offload_unit.sv
// Directed bench for cvxif_offload_unit: issue/full, reject path, writeback priority, flush, queue full
// and, with CVXIF_TIMEOUT_EN defined, the watchdog exception.
module tb_cvxif_offload_unit;
  import cvxif_offload_unit_pkg::*;

  localparam int unsigned NrRs = 2;

  logic                     clk_i = 1'b0;
  logic                     rst_i;
  logic                     flush_i;
  priv_lvl_t                priv_lvl_i;
  logic                     x_valid_i;
  logic                     x_ready_o;
  logic [31:0]              x_off_instr_i;
  logic [TRANS_ID_BITS-1:0] x_trans_id_i;
  logic [NrRs*XLEN-1:0]     x_rs_i;
  logic                     x_valid_o;
  logic [TRANS_ID_BITS-1:0] x_trans_id_o;
  logic [XLEN-1:0]          x_result_o;
  logic                     x_we_o;
  exception_t               x_exception_o;
  cvxif_req_t               cvxif_req_o;
  cvxif_resp_t              cvxif_resp_i;
  cvxif_req_t               exp_req;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  cvxif_offload_unit #(
    .NrOutstanding (4),
    .IllegalQDepth (2),
    .NrRs          (NrRs),
    .TimeoutCycles (8)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .flush_i       (flush_i),
    .priv_lvl_i    (priv_lvl_i),
    .x_valid_i     (x_valid_i),
    .x_ready_o     (x_ready_o),
    .x_off_instr_i (x_off_instr_i),
    .x_trans_id_i  (x_trans_id_i),
    .x_rs_i        (x_rs_i),
    .x_valid_o     (x_valid_o),
    .x_trans_id_o  (x_trans_id_o),
    .x_result_o    (x_result_o),
    .x_we_o        (x_we_o),
    .x_exception_o (x_exception_o),
    .cvxif_req_o   (cvxif_req_o),
    .cvxif_resp_i  (cvxif_resp_i)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // One cycle of stimulus: drive just after the rising edge, return at the falling edge for checks.
  task automatic applyStimulus(input logic valid, input logic [2:0] id, input logic [31:0] instr,
                               input logic accept, input logic rvalid, input logic [2:0] rid,
                               input logic [31:0] rdata, input logic rexc, input logic flush);
    @(posedge clk_i);
    #1;
    x_valid_i                            = valid;
    x_trans_id_i                         = id;
    x_off_instr_i                        = instr;
    x_rs_i                               = {32'hB000_0000 | 32'(id), 32'hA000_0000 | 32'(id)};
    cvxif_resp_i.x_issue_resp.accept     = accept;
    cvxif_resp_i.x_result_valid          = rvalid;
    cvxif_resp_i.x_result.id             = rid;
    cvxif_resp_i.x_result.data           = rdata;
    cvxif_resp_i.x_result.we             = ~rexc;
    cvxif_resp_i.x_result.exc            = rexc;
    cvxif_resp_i.x_result.exccode        = rexc ? 6'd5 : 6'd0;
    flush_i                              = flush;
    @(negedge clk_i);
  endtask

  task automatic idle();
    applyStimulus(1'b0, 3'd0, 32'h0, 1'b0, 1'b0, 3'd0, 32'h0, 1'b0, 1'b0);
  endtask

  initial begin
    rst_i         = 1'b1;
    flush_i       = 1'b0;
    priv_lvl_i    = PRIV_LVL_S;
    x_valid_i     = 1'b0;
    x_off_instr_i = '0;
    x_trans_id_i  = '0;
    x_rs_i        = '0;
    cvxif_resp_i  = '0;
    cvxif_resp_i.x_issue_ready = 1'b1;
    exp_req       = '0;
    exp_req.x_result_ready = 1'b1;

    // Reset then idle
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    @(negedge clk_i);
    checkOutput("rst_x_valid_o", x_valid_o, 0);
    checkOutput("rst_x_ready_o", x_ready_o, 1);
    checkOutput("rst_issue_valid", cvxif_req_o.x_issue_valid, 0);
    checks++;
    assert (cvxif_req_o === exp_req) else begin
      errors++;
      $error("[TB] FAIL rst_req_bus: observed 0x%0h expected 0x%0h", cvxif_req_o, exp_req);
    end
    cvxif_resp_i.x_issue_ready = 1'b0;
    #1;
    checkOutput("ready_follows_issue_ready_lo", x_ready_o, 0);
    cvxif_resp_i.x_issue_ready = 1'b1;
    #1;
    checkOutput("ready_follows_issue_ready_hi", x_ready_o, 1);

    // Fill the table with ids 1..4
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(1'b1, 3'(i), 32'h0000_100B + 32'(i), 1'b1, 1'b0, 3'd0, 32'h0, 1'b0, 1'b0);
      checkOutput("fill_ready", x_ready_o, 1);
      checkOutput("fill_no_wb", x_valid_o, 0);
      if (i == 1) begin
        checkOutput("issue_valid", cvxif_req_o.x_issue_valid, 1);
        checkOutput("issue_id", cvxif_req_o.x_issue_req.id, 1);
        checkOutput("issue_instr", cvxif_req_o.x_issue_req.instr, 32'h0000_100C);
        checkOutput("issue_mode", cvxif_req_o.x_issue_req.mode, 1);
        checkOutput("issue_rs1", cvxif_req_o.x_issue_req.rs[1], 32'hB000_0001);
        checkOutput("issue_rs0", cvxif_req_o.x_issue_req.rs[0], 32'hA000_0001);
        checkOutput("issue_rs_valid", cvxif_req_o.x_issue_req.rs_valid, 2'b11);
        checkOutput("commit_valid", cvxif_req_o.x_commit_valid, 1);
        checkOutput("commit_id", cvxif_req_o.x_commit.id, 1);
        checkOutput("commit_kill", cvxif_req_o.x_commit.x_kill, 0);
      end
    end
    applyStimulus(1'b1, 3'd5, 32'h0000_1010, 1'b1, 1'b0, 3'd0, 32'h0, 1'b0, 1'b0);
    checkOutput("full_ready", x_ready_o, 0);
    checkOutput("full_issue_valid", cvxif_req_o.x_issue_valid, 0);

    // Result for id 2 while full
    applyStimulus(1'b0, 3'd0, 32'h0, 1'b0, 1'b1, 3'd2, 32'h0000_BEEF, 1'b0, 1'b0);
    checkOutput("res2_valid", x_valid_o, 1);
    checkOutput("res2_id", x_trans_id_o, 2);
    checkOutput("res2_data", x_result_o, 32'h0000_BEEF);
    checkOutput("res2_we", x_we_o, 1);
    checkOutput("res2_exc", x_exception_o.valid, 0);
    checkOutput("res2_ready_still_lo", x_ready_o, 0);
    idle();
    checkOutput("after_free_ready", x_ready_o, 1);
    checkOutput("after_free_no_wb", x_valid_o, 0);

    // Rejected offload id 5
    applyStimulus(1'b1, 3'd5, 32'h0000_007B, 1'b0, 1'b0, 3'd0, 32'h0, 1'b0, 1'b0);
    checkOutput("rej5_ready", x_ready_o, 1);
    checkOutput("rej5_fire_no_wb", x_valid_o, 0);
    idle();
    checkOutput("rej5_valid", x_valid_o, 1);
    checkOutput("rej5_id", x_trans_id_o, 5);
    checkOutput("rej5_cause", x_exception_o.cause, 2);
    checkOutput("rej5_exc_valid", x_exception_o.valid, 1);
    checkOutput("rej5_tval", x_exception_o.tval, 32'h7B);
    checkOutput("rej5_we", x_we_o, 0);
    checkOutput("rej5_result", x_result_o, 0);
    idle();
    checkOutput("rej5_single_wb", x_valid_o, 0);

    // Rejected id 6 loses to matched result id 1
    applyStimulus(1'b1, 3'd6, 32'h0000_005B, 1'b0, 1'b0, 3'd0, 32'h0, 1'b0, 1'b0);
    checkOutput("rej6_fire_no_wb", x_valid_o, 0);
    applyStimulus(1'b0, 3'd0, 32'h0, 1'b0, 1'b1, 3'd1, 32'h0000_1111, 1'b0, 1'b0);
    checkOutput("prio_res1_id", x_trans_id_o, 1);
    checkOutput("prio_res1_data", x_result_o, 32'h0000_1111);
    checkOutput("prio_res1_exc", x_exception_o.valid, 0);
    idle();
    checkOutput("prio_rej6_valid", x_valid_o, 1);
    checkOutput("prio_rej6_id", x_trans_id_o, 6);
    checkOutput("prio_rej6_tval", x_exception_o.tval, 32'h5B);
    checkOutput("prio_rej6_cause", x_exception_o.cause, 2);
    idle();
    checkOutput("prio_done", x_valid_o, 0);

    // Flush with ids 3 and 4 in flight; result in the flush cycle is still emitted
    applyStimulus(1'b1, 3'd7, 32'h0000_0077, 1'b1, 1'b1, 3'd3, 32'h0000_3333, 1'b0, 1'b1);
    checkOutput("flush_ready", x_ready_o, 0);
    checkOutput("flush_issue_valid", cvxif_req_o.x_issue_valid, 0);
    checkOutput("flush_wb_valid", x_valid_o, 1);
    checkOutput("flush_wb_id", x_trans_id_o, 3);
    checkOutput("flush_wb_data", x_result_o, 32'h0000_3333);
    applyStimulus(1'b0, 3'd0, 32'h0, 1'b0, 1'b1, 3'd4, 32'h0000_4444, 1'b0, 1'b0);
    checkOutput("flushed_id4_dropped", x_valid_o, 0);
    checkOutput("post_flush_ready", x_ready_o, 1);
    applyStimulus(1'b0, 3'd0, 32'h0, 1'b0, 1'b1, 3'd3, 32'h0000_3333, 1'b0, 1'b0);
    checkOutput("flushed_id3_dropped", x_valid_o, 0);
    applyStimulus(1'b1, 3'd1, 32'h0000_0101, 1'b1, 1'b0, 3'd0, 32'h0, 1'b0, 1'b0);
    checkOutput("refill1_ready", x_ready_o, 1);
    applyStimulus(1'b1, 3'd2, 32'h0000_0102, 1'b1, 1'b0, 3'd0, 32'h0, 1'b0, 1'b0);
    checkOutput("refill2_ready", x_ready_o, 1);
    idle();
    checkOutput("table_emptied_ready", x_ready_o, 1);

    // Fill the illegal queue while results hold off the pops
    applyStimulus(1'b1, 3'd5, 32'h0000_0015, 1'b0, 1'b0, 3'd0, 32'h0, 1'b0, 1'b0);
    checkOutput("q1_no_wb", x_valid_o, 0);
    applyStimulus(1'b1, 3'd6, 32'h0000_0016, 1'b0, 1'b1, 3'd1, 32'h0000_AAAA, 1'b0, 1'b0);
    checkOutput("q2_ready", x_ready_o, 1);
    checkOutput("q2_wb_id", x_trans_id_o, 1);
    checkOutput("q2_wb_data", x_result_o, 32'h0000_AAAA);
    applyStimulus(1'b0, 3'd0, 32'h0, 1'b0, 1'b1, 3'd2, 32'h0, 1'b1, 1'b0);
    checkOutput("qfull_ready", x_ready_o, 0);
    checkOutput("exc_res_id", x_trans_id_o, 2);
    checkOutput("exc_res_valid", x_exception_o.valid, 1);
    checkOutput("exc_res_cause", x_exception_o.cause, 5);
    checkOutput("exc_res_tval", x_exception_o.tval, 0);
    checkOutput("exc_res_we", x_we_o, 0);
    idle();
    checkOutput("qdrain5_ready", x_ready_o, 0);
    checkOutput("qdrain5_id", x_trans_id_o, 5);
    checkOutput("qdrain5_tval", x_exception_o.tval, 32'h15);
    idle();
    checkOutput("qdrain6_ready", x_ready_o, 1);
    checkOutput("qdrain6_id", x_trans_id_o, 6);
    checkOutput("qdrain6_tval", x_exception_o.tval, 32'h16);
    idle();
    checkOutput("qdrained", x_valid_o, 0);

    // An accepted offload that never gets a result
    applyStimulus(1'b1, 3'd7, 32'h0000_00AB, 1'b1, 1'b0, 3'd0, 32'h0, 1'b0, 1'b0);
    checkOutput("to_issue_ready", x_ready_o, 1);
    repeat (7) idle();
    checkOutput("to_not_yet", x_valid_o, 0);
    idle();
`ifdef CVXIF_TIMEOUT_EN
    checkOutput("to_valid", x_valid_o, 1);
    checkOutput("to_id", x_trans_id_o, 7);
    checkOutput("to_cause", x_exception_o.cause, 2);
    checkOutput("to_tval", x_exception_o.tval, 32'hAB);
    checkOutput("to_we", x_we_o, 0);
    idle();
    checkOutput("to_single_wb", x_valid_o, 0);
`else
    checkOutput("no_to_waits", x_valid_o, 0);
    repeat (4) idle();
    checkOutput("no_to_still_waits", x_valid_o, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
